// File: rtl/counter_sequencer.sv
// Button-driven run/step/load sequencer for a counter cascade, with rate divider and page pointer.
// Define COUNTER_SEQUENCER_STOP_ON_WRAP_EN to make a wrap event in RUN drop back to STOP.

module counter_sequencer_db #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic ce1ms,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_MS + 1);

  logic [1:0]    sync;
  logic          deb, deb_q;
  logic [CW-1:0] cnt;

  // cnt tracks consecutive ticks on which the synchronised level disagreed with deb
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= '0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      cnt   <= '0;
    end else begin
      sync  <= {sync[0], btn};
      deb_q <= deb;
      if (ce1ms) begin
        if (sync[1] == deb) cnt <= '0;
        else if (cnt == CW'(DEBOUNCE_MS - 1)) begin
          deb <= sync[1];
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = deb & ~deb_q;
endmodule

module counter_sequencer #(
  parameter int DEBOUNCE_MS = 20,
  parameter int RATE_DIV    = 25,
  parameter int PAGE_MS     = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce1ms,
  input  logic       btn_run,
  input  logic       btn_step,
  input  logic       btn_load,
  input  logic       tmod,
  input  logic       cnt_ceo,
  output logic       cnt_ce,
  output logic       cnt_load,
  output logic [1:0] state,
  output logic       ovf,
  output logic [1:0] ptr
);
  localparam int NUM_BTN = 3;

  typedef enum logic [1:0] {STOP = 2'b00, RUN = 2'b01, STEP = 2'b10, LOAD = 2'b11} state_t;

  logic [NUM_BTN-1:0] btn, press;
  state_t             st, nst;
  logic [9:0]         div;
  logic [15:0]        pg;
  logic               p_load, p_run, p_step, wrap, div_hit, run_ce;

  assign btn = {btn_load, btn_run, btn_step};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    counter_sequencer_db #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db (
      .clk(clk), .rst(rst), .ce1ms(ce1ms), .btn(btn[i]), .press(press[i])
    );
  end

  assign p_load = press[2];
  assign p_run  = press[1] & ~press[2];
  assign p_step = press[0] & ~press[1] & ~press[2];
  assign wrap   = cnt_ce & cnt_ceo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= STOP;
    else      st <= nst;
  end

  always_comb begin
    nst = st;
    unique case (st)
      STOP: begin
        if (p_load)      nst = LOAD;
        else if (p_run)  nst = RUN;
        else if (p_step) nst = STEP;
      end
      RUN: begin
        if (p_load)      nst = LOAD;
        else if (p_run)  nst = STOP;
`ifdef COUNTER_SEQUENCER_STOP_ON_WRAP_EN
        else if (wrap)   nst = STOP;
`endif
      end
      STEP:    nst = STOP;
      LOAD:    nst = STOP;
      default: nst = STOP;
    endcase
  end

  assign div_hit = (div == 10'(RATE_DIV - 1));
  // RUN pulses only while staying in RUN, so cnt_ce never lands in STOP or LOAD
  assign run_ce  = (st == RUN) && (nst == RUN) && ce1ms && (tmod || div_hit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_ce   <= 1'b0;
      cnt_load <= 1'b0;
      div      <= '0;
      ovf      <= 1'b0;
    end else begin
      cnt_ce   <= (nst == STEP) || run_ce;
      cnt_load <= (nst == LOAD);
      if (st != RUN) begin
        if (nst == RUN) div <= '0;
      end else if (tmod) div <= '0;
      else if (ce1ms) div <= div_hit ? 10'd0 : div + 10'd1;
      if (st == LOAD) ovf <= 1'b0;
      else if (wrap)  ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pg  <= '0;
      ptr <= '0;
    end else if (ce1ms) begin
      if (pg == 16'(PAGE_MS - 1)) begin
        pg  <= '0;
        ptr <= ptr + 2'd1;
      end else pg <= pg + 16'd1;
    end
  end

  assign state = st;
endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: vector table, hand sequences and random stimulus vs. a behavioural model.
module tb_counter_sequencer;
  localparam int DEB = 2, RDIV = 3, PMS = 4;
  localparam int S_STOP = 0, S_RUN = 1, S_STEP = 2, S_LOAD = 3;
`ifdef COUNTER_SEQUENCER_STOP_ON_WRAP_EN
  localparam int WRAP_ST = S_STOP;
`else
  localparam int WRAP_ST = S_RUN;
`endif

  logic clk = 0, rst = 1, ce1ms = 0, btn_run = 0, btn_step = 0, btn_load = 0, tmod = 0, cnt_ceo = 0;
  logic cnt_ce, cnt_load, ovf;
  logic [1:0] state, ptr;

  always #5 clk = ~clk;

  counter_sequencer #(.DEBOUNCE_MS(DEB), .RATE_DIV(RDIV), .PAGE_MS(PMS)) dut (
    .clk(clk), .rst(rst), .ce1ms(ce1ms), .btn_run(btn_run), .btn_step(btn_step),
    .btn_load(btn_load), .tmod(tmod), .cnt_ceo(cnt_ceo), .cnt_ce(cnt_ce),
    .cnt_load(cnt_load), .state(state), .ovf(ovf), .ptr(ptr)
  );

  int n_chk = 0, n_pass = 0, ce_cnt = 0, ld_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: debounce as a window of tick samples, rates and pages from tick totals
  bit [2:0]     mh1, mh2, mdeb, mdebq;
  bit [DEB-1:0] msamp [3];
  int           mst, mrt, mtot;
  bit           mce, mld, movf;

  function automatic void m_reset();
    mh1 = 0; mh2 = 0; mdeb = 0; mdebq = 0;
    for (int b = 0; b < 3; b++) msamp[b] = '0;
    mst = S_STOP; mrt = 0; mtot = 0; mce = 0; mld = 0; movf = 0;
  endfunction

  function automatic void m_edge();
    bit [2:0] p;
    bit pl, pr, ps, wrap;
    int nst;
    p  = mdeb & ~mdebq;
    pl = p[2];
    pr = p[1] & ~pl;
    ps = p[0] & ~p[1] & ~pl;
    wrap = mce & cnt_ceo;
    case (mst)
      S_STOP: nst = pl ? S_LOAD : pr ? S_RUN : ps ? S_STEP : S_STOP;
      S_RUN: begin
        nst = pl ? S_LOAD : pr ? S_STOP : S_RUN;
`ifdef COUNTER_SEQUENCER_STOP_ON_WRAP_EN
        if (nst == S_RUN && wrap) nst = S_STOP;
`endif
      end
      default: nst = S_STOP;
    endcase
    mce  = (nst == S_STEP) ||
           (mst == S_RUN && nst == S_RUN && ce1ms && (tmod || (mrt + 1) % RDIV == 0));
    mld  = (nst == S_LOAD);
    movf = (mst == S_LOAD) ? 1'b0 : (movf | wrap);
    if (mst == S_RUN) begin
      if (tmod) mrt = 0;
      else if (ce1ms) mrt++;
    end else mrt = 0;
    mdebq = mdeb;
    if (ce1ms) begin
      mtot++;
      for (int b = 0; b < 3; b++) begin
        msamp[b] = {msamp[b][DEB-2:0], mh2[b]};
        if (msamp[b] == (mdeb[b] ? {DEB{1'b0}} : {DEB{1'b1}})) mdeb[b] = ~mdeb[b];
      end
    end
    mh2 = mh1;
    mh1 = {btn_load, btn_run, btn_step};
    mst = nst;
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst) m_reset();
    else m_edge();
    #1;
    if (cnt_ce) ce_cnt++;
    if (cnt_load) ld_cnt++;
    n_chk++;
    if ({state, cnt_ce, cnt_load, ovf, ptr} == {2'(mst), mce, mld, movf, 2'((mtot / PMS) % 4)})
      n_pass++;
    else
      $display("FAIL cycle @%0t: got st=%0d ce=%b ld=%b ovf=%b ptr=%0d expected st=%0d ce=%b ld=%b ovf=%b ptr=%0d",
               $time, state, cnt_ce, cnt_load, ovf, ptr, mst, mce, mld, movf, (mtot / PMS) % 4);
  endtask

  task automatic ms_tick();
    ce1ms = 1; step();
    ce1ms = 0; repeat (9) step();
  endtask

  task automatic do_reset();
    rst = 0; m_reset();
    {btn_load, btn_run, btn_step} = 3'b000; tmod = 0; cnt_ceo = 0; ce1ms = 0;
    repeat (2) step();
    rst = 1; ce_cnt = 0; ld_cnt = 0;
  endtask

  typedef struct {
    logic [2:0] btn;   // {load, run, step}
    int hold; logic tmod; int ticks;
    int st; int ce; int ld; int ptr;
  } vec_t;
  vec_t vt [9];

  initial begin
    vt[0] = '{3'b010, 1, 1'b0, 9,  S_STOP, 0, 0, 2};
    vt[1] = '{3'b010, 3, 1'b0, 9,  S_RUN,  3, 0, 3};
    vt[2] = '{3'b010, 3, 1'b1, 9,  S_RUN,  9, 0, 3};
    vt[3] = '{3'b001, 3, 1'b0, 5,  S_STOP, 1, 0, 2};
    vt[4] = '{3'b110, 3, 1'b0, 5,  S_STOP, 0, 1, 2};
    vt[5] = '{3'b100, 3, 1'b0, 13, S_STOP, 0, 1, 0};
    vt[6] = '{3'b011, 3, 1'b0, 9,  S_RUN,  3, 0, 3};
    vt[7] = '{3'b000, 3, 1'b0, 1,  S_STOP, 0, 0, 1};
    vt[8] = '{3'b011, 3, 1'b1, 9,  S_RUN,  9, 0, 3};

    #2;
    do_reset();
    check("reset_state", int'(state), S_STOP);
    check("reset_outs", int'({cnt_ce, cnt_load, ovf, ptr}), 0);

    foreach (vt[i]) begin
      do_reset();
      {btn_load, btn_run, btn_step} = vt[i].btn;
      tmod = vt[i].tmod;
      repeat (vt[i].hold) ms_tick();
      {btn_load, btn_run, btn_step} = 3'b000;
      repeat (vt[i].ticks) ms_tick();
      check($sformatf("vec%0d_state", i), int'(state), vt[i].st);
      check($sformatf("vec%0d_ce_count", i), ce_cnt, vt[i].ce);
      check($sformatf("vec%0d_load_count", i), ld_cnt, vt[i].ld);
      check($sformatf("vec%0d_ptr", i), int'(ptr), vt[i].ptr);
    end

    // wrap sets ovf, then a combined load+run press clears it via LOAD
    do_reset();
    btn_run = 1; repeat (3) ms_tick(); btn_run = 0;
    tmod = 1; cnt_ceo = 1; ms_tick(); cnt_ceo = 0;
    check("wrap_ovf", int'(ovf), 1);
    check("wrap_state", int'(state), WRAP_ST);
    ld_cnt = 0;
    btn_load = 1; btn_run = 1; repeat (3) ms_tick(); btn_load = 0; btn_run = 0;
    ms_tick();
    check("load_state", int'(state), S_STOP);
    check("load_ovf", int'(ovf), 0);
    check("load_count", ld_cnt, 1);

    // page pointer walks 0..3 and wraps
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      repeat (4) ms_tick();
      check($sformatf("page%0d_ptr", k), int'(ptr), k % 4);
    end

    // asynchronous reset mid-RUN, button held through release
    do_reset();
    btn_run = 1; tmod = 1;
    repeat (5) ms_tick();
    ce1ms = 1; step(); ce1ms = 0;
    check("prereset_ce", int'(cnt_ce), 1);
    #2 rst = 0;
    #1;
    check("async_rst_state", int'(state), S_STOP);
    check("async_rst_outs", int'({cnt_ce, cnt_load, ovf, ptr}), 0);
    m_reset();
    repeat (3) step();
    rst = 1;
    repeat (2) ms_tick();
    check("held_thru_rst_early", int'(state), S_STOP);
    ms_tick();
    check("held_thru_rst_late", int'(state), S_RUN);

    // random buttons, tmod, carry and occasional resets against the model
    do_reset();
    for (int t = 0; t < 300; t++) begin
      int k;
      logic [2:0] nb;
      if ($urandom_range(0, 63) == 0) do_reset();
      if ($urandom_range(0, 7) == 0) tmod = ~tmod;
      k  = $urandom_range(0, 9);
      nb = {btn_load, btn_run, btn_step} ^
           {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)};
      for (int c = 0; c < 10; c++) begin
        ce1ms = (c == 0);
        cnt_ceo = 1'($urandom_range(0, 1));
        if (c == k) {btn_load, btn_run, btn_step} = nb;
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter DEBOUNCE_MS, default 20: consecutive ce1ms ticks a raw button level must be stable before it is accepted.
REQ-002 Parameter RATE_DIV, default 25: ce1ms ticks per cnt_ce pulse in RUN when tmod=0; legal range 1..1023.
REQ-003 Parameter PAGE_MS, default 1000: ce1ms ticks per display page advance; legal range 1..65535.
REQ-004 clk  input  1  single system clock; all logic rising-edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 ce1ms  input  1  one-clk-wide 1 ms tick.
REQ-007 btn_run, btn_step, btn_load  input  1 each  raw, unsynchronised push-buttons, active-high.
REQ-008 tmod  input  1  fast mode: 1 = one cnt_ce per ce1ms tick in RUN.
REQ-009 cnt_ceo  input  1  terminal-count carry from the last counter stage.
REQ-010 cnt_ce  output  1  one-clk count enable to the counter cascade.
REQ-011 cnt_load  output  1  one-clk load strobe to the loadable stage.
REQ-012 state  output  2  FSM state: STOP=00, RUN=01, STEP=10, LOAD=11.
REQ-013 ovf  output  1  sticky wrap flag.
REQ-014 ptr  output  2  display page select.

Function
REQ-015 Each button SHALL pass a 2-flop synchroniser; the debounced level SHALL update only when the synchronised level has matched a new value on DEBOUNCE_MS consecutive ce1ms ticks.
REQ-016 A 0->1 debounced transition SHALL produce a one-clk press pulse; releases produce nothing.
REQ-017 Simultaneous press pulses SHALL be prioritised load > run > step; lower-priority presses in the same clk are discarded.
REQ-018 STOP: load press -> LOAD; run press -> RUN; step press -> STEP; otherwise hold.
REQ-019 RUN: run press -> STOP; load press -> LOAD; step press ignored.
REQ-020 STEP: cnt_ce=1 for exactly the one clk spent in STEP, then -> STOP unconditionally.
REQ-021 LOAD: cnt_load=1 for exactly the one clk spent in LOAD, ovf cleared, then -> STOP.
REQ-022 Rate divider (10 bits) SHALL clear on every entry into RUN and hold while not in RUN.
REQ-023 RUN, tmod=0: on ce1ms with divider=RATE_DIV-1, cnt_ce=1 next clk and divider -> 0; else divider increments on ce1ms.
REQ-024 RUN, tmod=1: cnt_ce SHALL be ce1ms registered one clk; divider held at 0.
REQ-025 cnt_ce and cnt_load SHALL never be high in the same clk; cnt_ce=0 in STOP and LOAD.
REQ-026 Wrap event = cnt_ce and cnt_ceo both high in one clk; it SHALL set ovf on the next clk; ovf clears only in LOAD or reset; a wrap and LOAD-clear in the same clk resolve to ovf=0.
REQ-027 Page counter (16 bits) SHALL count ce1ms in all states; at PAGE_MS-1 it wraps to 0 and ptr increments, 3 -> 0.

Reset
REQ-028 rst=0 SHALL asynchronously force state=STOP, cnt_ce=0, cnt_load=0, ovf=0, ptr=00, all counters/divider=0, synchronisers and debounced levels=0.
REQ-029 Reset mid-RUN or mid-debounce SHALL discard pending presses; a button held through reset release SHALL produce a press only after DEBOUNCE_MS ticks.

Configuration
REQ-030 Macro COUNTER_SEQUENCER_STOP_ON_WRAP_EN defined: a wrap event in RUN SHALL also force RUN -> STOP next clk (run press same clk -> STOP, load press -> LOAD wins).
REQ-031 Macro undefined: wrap events SHALL only set ovf; RUN continues.

Verification (DEBOUNCE_MS=2, RATE_DIV=3, PAGE_MS=4, ce1ms every 10 clk)
REQ-032 btn_run high 1 tick then low -> no press; held 3 ticks -> state 00->01 once.
REQ-033 RUN, tmod=0, 9 ce1ms ticks -> exactly 3 cnt_ce pulses, each 1 clk; tmod=1 -> 9 pulses.
REQ-034 STOP, btn_step press -> state 10 for 1 clk with cnt_ce=1, then 00; no further cnt_ce.
REQ-035 btn_load and btn_run debounced same clk -> state 11, cnt_load=1 for 1 clk, then 00; ovf 1->0.
REQ-036 RUN, cnt_ceo=1 during a cnt_ce -> ovf=1; with macro state->00, without stays 01.
REQ-037 16 ce1ms ticks from reset -> ptr 00,01,10,11,00; rst low mid-RUN -> all outputs 0, state 00 immediately.
